fetch_unit: RTL

- Instruction-fetch stage of the RV32I core. Owns the PC, issues one-outstanding requests to instruction memory, and presents fetched words to decode through a valid/ready output register.
- Consumes the redirect produced from branch comparison and jump resolution: on a taken branch or jump it flushes wrong-path work and refetches from the target.

---
 rtl/fetch_unit_pkg.sv | 15 +
 rtl/fetch_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants for the RV32I core.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight and
// feeds decode through a valid/ready output register with an inline skid slot.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr,
  input  logic            id_ready
);

  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(INSTR_BYTES - 1);

  fetch_state_t    state_r;
  logic [XLEN-1:0] pc_r;
  logic            outstanding_r;
  logic [31:0]     pend_instr_r;
  logic [XLEN-1:0] pend_pc_r;
  logic            rvalid_s;
  logic            out_free_s;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & ALIGN_MSK;
  endfunction

  // Request gate and response qualification; a response with nothing in flight is dropped.
  always_comb begin
    rvalid_s   = imem_rvalid && outstanding_r;
    out_free_s = !if_valid || id_ready;
    imem_addr  = pc_r;
    if (state_r == ISSUE) begin
      imem_req = !redirect && !rst;
    end else begin
      imem_req = 1'b0;
    end
  end

  // Fetch FSM, PC, skid slot and decode output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ISSUE;
      pc_r          <= RESET_PC;
      outstanding_r <= 1'b0;
      pend_instr_r  <= NOP_INSTR;
      pend_pc_r     <= {XLEN{1'b0}};
      if_valid      <= 1'b0;
      if_pc         <= {XLEN{1'b0}};
      if_instr      <= NOP_INSTR;
    end else begin
      if (if_valid && id_ready) begin
        if_valid <= 1'b0;
      end
      case (state_r)
        ISSUE: begin
          if (!redirect) begin
            state_r       <= WAIT;
            outstanding_r <= 1'b1;
          end
        end
        WAIT: begin
          if (rvalid_s) begin
            outstanding_r <= 1'b0;
            if (redirect) begin
              state_r <= ISSUE;
            end else if (out_free_s) begin
              if_valid <= 1'b1;
              if_instr <= imem_rdata;
              if_pc    <= pc_r;
              pc_r     <= pc_r + PC_STEP;
              state_r  <= ISSUE;
            end else begin
              pend_instr_r <= imem_rdata;
              pend_pc_r    <= pc_r;
              state_r      <= HOLD;
            end
          end else if (redirect) begin
            state_r <= DRAIN;
          end
        end
        HOLD: begin
          if (redirect) begin
            state_r <= ISSUE;
          end else if (id_ready) begin
            if_valid <= 1'b1;
            if_instr <= pend_instr_r;
            if_pc    <= pend_pc_r;
            pc_r     <= pc_r + PC_STEP;
            state_r  <= ISSUE;
          end
        end
        DRAIN: begin
          // A redirect landing with the drained response still leaves nothing in flight.
          if (rvalid_s) begin
            outstanding_r <= 1'b0;
            state_r       <= ISSUE;
          end
        end
        default: begin
          state_r       <= ISSUE;
          outstanding_r <= 1'b0;
        end
      endcase
      if (redirect) begin
        pc_r     <= align_pc(redirect_pc);
        if_valid <= 1'b0;
      end
    end
  end

endmodule
